// File: rtl/crypt_reg_slave_pkg.sv
// Shared AHB codes, register map and state types for the encryption-engine register slave.
package crypt_reg_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int unsigned CH_STRIDE = 32'h20;

  // Word index inside a channel bank; byte offset is the value times four.
  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PADDR  = 3'd1,
    REG_FSIZE  = 3'd2,
    REG_CADDR  = 3'd3,
    REG_SEED_L = 3'd4,
    REG_SEED_M = 3'd5,
    REG_STATUS = 3'd6,
    REG_RSVD   = 3'd7
  } reg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR2
  } dp_state_e;

  function automatic logic [31:0] id_word(input int unsigned num_ch);
    return {16'hC0DE, num_ch[7:0], 8'h01};
  endfunction

endpackage

// File: rtl/crypt_reg_slave_if.sv
// AHB-Lite slave-side signal bundle for the register slave.
interface crypt_reg_slave_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADYin;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYout;
  logic [1:0]  HRESP;

  modport slave (
    input  HSEL, HTRANS, HWRITE, HSIZE, HREADYin, HADDR, HWDATA,
    output HRDATA, HREADYout, HRESP
  );

  modport master (
    output HSEL, HTRANS, HWRITE, HSIZE, HREADYin, HADDR, HWDATA,
    input  HRDATA, HREADYout, HRESP
  );
endinterface

// File: rtl/crypt_reg_slave_ch_regs.sv
// One channel's config bank plus BUSY/DONE/IE state, start pulse and interrupt bit.
module crypt_ch_regs
  import crypt_reg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  reg_e        i_wreg,
  input  logic [31:0] i_wdata,
  input  reg_e        i_rreg,
  input  logic        i_done,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_start,
  output logic        o_irq,
  output logic [31:0] o_plain_addr,
  output logic [31:0] o_frame_size,
  output logic [31:0] o_cipher_addr,
  output logic [63:0] o_seed
);

  logic [31:0] r_paddr, r_fsize, r_caddr, r_seed_l, r_seed_m;
  logic        r_busy, r_done, r_ie, r_start, r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_paddr  <= '0;
      r_fsize  <= '0;
      r_caddr  <= '0;
      r_seed_l <= '0;
      r_seed_m <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ie     <= 1'b0;
      r_start  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_irq   <= r_done & r_ie;
      if (i_we) begin
        case (i_wreg)
          REG_CTRL: begin
            r_ie <= i_wdata[1];
            if (i_wdata[0] && !r_busy) begin
              r_busy  <= 1'b1;
              r_start <= 1'b1;
            end
          end
          REG_PADDR:  r_paddr  <= i_wdata;
          REG_FSIZE:  r_fsize  <= i_wdata;
          REG_CADDR:  r_caddr  <= i_wdata;
          REG_SEED_L: r_seed_l <= i_wdata;
          REG_SEED_M: r_seed_m <= i_wdata;
          REG_STATUS: if (i_wdata[1]) r_done <= 1'b0;
          default: ;
        endcase
      end
      // Placed after the W1C so a coincident engine completion keeps DONE set.
      if (i_done && r_busy) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_rreg)
      REG_CTRL:   o_rdata = {30'b0, r_ie, 1'b0};
      REG_PADDR:  o_rdata = r_paddr;
      REG_FSIZE:  o_rdata = r_fsize;
      REG_CADDR:  o_rdata = r_caddr;
      REG_SEED_L: o_rdata = r_seed_l;
      REG_SEED_M: o_rdata = r_seed_m;
      REG_STATUS: o_rdata = {30'b0, r_done, r_busy};
      default:    o_rdata = '0;
    endcase
  end

  assign o_busy        = r_busy;
  assign o_start       = r_start;
  assign o_irq         = r_irq;
  assign o_plain_addr  = r_paddr;
  assign o_frame_size  = r_fsize;
  assign o_cipher_addr = r_caddr;
  assign o_seed        = {r_seed_m, r_seed_l};

endmodule

// File: rtl/crypt_reg_slave.sv
// AHB-Lite register slave fronting NUM_CH encryption channels: pipeline, wait states, decode, errors.
module crypt_reg_slave
  import crypt_reg_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  crypt_reg_slave_if.slave      ahb,
  output logic [NUM_CH-1:0]     ch_start,
  output logic [NUM_CH*32-1:0]  ch_plain_addr,
  output logic [NUM_CH*32-1:0]  ch_frame_size,
  output logic [NUM_CH*32-1:0]  ch_cipher_addr,
  output logic [NUM_CH*64-1:0]  ch_seed,
  input  logic [NUM_CH-1:0]     ch_done,
  output logic                  irq
);

  localparam int unsigned IW = ADDR_BITS - 5;

  dp_state_e             r_state, w_state_nx;
  logic [3:0]            r_cnt, w_cnt_nx;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_write;
  logic [2:0]            r_size;

  logic [IW-1:0]  w_idx;
  reg_e           w_reg;
  logic           w_ch_hit, w_id_hit, w_busy_sel, w_cfg_wr, w_err;
  logic           w_accept, w_free, w_take, w_commit;
  logic [31:0]    w_rdata_sel;
  logic [31:0]    w_ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] w_busy, w_we, w_irq_ch;

  assign w_accept = ahb.HSEL & ahb.HREADYin &
                    ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));

  assign w_idx    = r_addr[ADDR_BITS-1:5];
  assign w_reg    = reg_e'(r_addr[4:2]);
  assign w_ch_hit = (32'(w_idx) < NUM_CH);
  assign w_id_hit = (32'(w_idx) == NUM_CH) && (w_reg == REG_CTRL);
  assign w_cfg_wr = (w_reg inside {REG_PADDR, REG_FSIZE, REG_CADDR, REG_SEED_L, REG_SEED_M}) ||
                    ((w_reg == REG_CTRL) && ahb.HWDATA[0]);

  always_comb begin
    w_busy_sel  = 1'b0;
    w_rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(w_idx) == i) begin
        w_busy_sel  = w_busy[i];
        w_rdata_sel = w_ch_rdata[i];
      end
    end
  end

  // Evaluated in the final data-phase cycle so START-while-BUSY can see HWDATA.
  assign w_err = (r_size != HSIZE_WORD) ||
                 (r_addr[1:0] != 2'b00) ||
                 !((w_ch_hit && (w_reg != REG_RSVD)) || w_id_hit) ||
                 (r_write && w_id_hit) ||
                 (r_write && w_ch_hit && w_busy_sel && w_cfg_wr);

  assign w_free   = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                    ((r_state == ST_RESP) && !w_err);
  assign w_take   = w_accept & w_free;
  assign w_commit = (r_state == ST_RESP) && r_write && !w_err;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_take) begin
        r_addr  <= ahb.HADDR[ADDR_BITS-1:0];
        r_write <= ahb.HWRITE;
        r_size  <= ahb.HSIZE;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: ;
      ST_WAIT: begin
        if (r_cnt == 4'd1) w_state_nx = ST_RESP;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      ST_RESP: w_state_nx = w_err ? ST_ERR2 : ST_IDLE;
      ST_ERR2: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_take) begin
      if (WAIT_STATES == 0) begin
        w_state_nx = ST_RESP;
      end else begin
        w_state_nx = ST_WAIT;
        w_cnt_nx   = 4'(WAIT_STATES);
      end
    end
  end

  always_comb begin
    ahb.HREADYout = 1'b1;
    ahb.HRESP     = HRESP_OKAY;
    ahb.HRDATA    = '0;
    case (r_state)
      ST_WAIT: ahb.HREADYout = 1'b0;
      ST_RESP: begin
        if (w_err) begin
          ahb.HREADYout = 1'b0;
          ahb.HRESP     = HRESP_ERROR;
        end else if (!r_write) begin
          ahb.HRDATA = w_id_hit ? id_word(NUM_CH) : w_rdata_sel;
        end
      end
      ST_ERR2: ahb.HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_we[g] = w_commit && w_ch_hit && (32'(w_idx) == 32'(g));

    crypt_ch_regs u_ch (
      .i_clk         (HCLK),
      .i_rst         (HRESET),
      .i_we          (w_we[g]),
      .i_wreg        (w_reg),
      .i_wdata       (ahb.HWDATA),
      .i_rreg        (w_reg),
      .i_done        (ch_done[g]),
      .o_rdata       (w_ch_rdata[g]),
      .o_busy        (w_busy[g]),
      .o_start       (ch_start[g]),
      .o_irq         (w_irq_ch[g]),
      .o_plain_addr  (ch_plain_addr[32*g +: 32]),
      .o_frame_size  (ch_frame_size[32*g +: 32]),
      .o_cipher_addr (ch_cipher_addr[32*g +: 32]),
      .o_seed        (ch_seed[64*g +: 64])
    );
  end

  assign irq = |w_irq_ch;

endmodule

// File: tb/tb_crypt_reg_slave.sv
// Directed bench: a zero-wait instance and a three-wait instance share one AHB driver.
module tb_crypt_reg_slave;
  import crypt_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        t_sel = 1'b0;
  logic        t_hsel = 1'b0;
  logic [1:0]  t_htrans = HTRANS_IDLE;
  logic        t_hwrite = 1'b0;
  logic [2:0]  t_hsize = HSIZE_WORD;
  logic [31:0] t_haddr = '0;
  logic [31:0] t_hwdata = '0;
  logic [3:0]  c_done = '0;

  crypt_reg_slave_if bus0 ();
  crypt_reg_slave_if bus3 ();

  assign bus0.HSEL = t_hsel & ~t_sel;
  assign bus3.HSEL = t_hsel & t_sel;
  assign bus0.HTRANS = t_htrans;   assign bus3.HTRANS = t_htrans;
  assign bus0.HWRITE = t_hwrite;   assign bus3.HWRITE = t_hwrite;
  assign bus0.HSIZE  = t_hsize;    assign bus3.HSIZE  = t_hsize;
  assign bus0.HADDR  = t_haddr;    assign bus3.HADDR  = t_haddr;
  assign bus0.HWDATA = t_hwdata;   assign bus3.HWDATA = t_hwdata;
  assign bus0.HREADYin = bus0.HREADYout;
  assign bus3.HREADYin = bus3.HREADYout;

  logic [3:0]   st0, st3;
  logic [127:0] pa0, fs0, ca0, pa3, fs3, ca3;
  logic [255:0] sd0, sd3;
  logic         irq0, irq3;

  crypt_reg_slave #(.NUM_CH(4), .ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .ahb(bus0), .ch_start(st0), .ch_plain_addr(pa0),
    .ch_frame_size(fs0), .ch_cipher_addr(ca0), .ch_seed(sd0), .ch_done(c_done), .irq(irq0)
  );

  crypt_reg_slave #(.NUM_CH(4), .ADDR_BITS(12), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .ahb(bus3), .ch_start(st3), .ch_plain_addr(pa3),
    .ch_frame_size(fs3), .ch_cipher_addr(ca3), .ch_seed(sd3), .ch_done(c_done), .irq(irq3)
  );

  logic        m_rdy;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  assign m_rdy   = t_sel ? bus3.HREADYout : bus0.HREADYout;
  assign m_resp  = t_sel ? bus3.HRESP     : bus0.HRESP;
  assign m_rdata = t_sel ? bus3.HRDATA    : bus0.HRDATA;

  // Single non-pipelined transfer; returns one ns after the final data-phase edge.
  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, output logic [31:0] rd, output logic [1:0] resp,
                          output int waits, output logic err1);
    bit got;
    rd = '0; resp = HRESP_OKAY; waits = 0; err1 = 1'b0; got = 1'b0;
    @(negedge clk);
    t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_hwrite = wr; t_haddr = addr; t_hsize = size;
    @(posedge clk); #1;
    t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = wdata;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (m_rdy) begin
        rd = m_rdata; resp = m_resp; got = 1'b1;
      end else if (m_resp == HRESP_ERROR) err1 = 1'b1;
      else waits++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h got no HREADYout within 40 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus0.HREADYout !== 1'b1 || bus3.HREADYout !== 1'b1) begin errors++;
      $display("FAIL reset_hready got %b/%b exp 1/1", bus0.HREADYout, bus3.HREADYout); end
    checks++; if (bus0.HRESP !== 2'b00 || bus0.HRDATA !== 32'h0) begin errors++;
      $display("FAIL reset_resp_rdata got %b/%h exp 00/0", bus0.HRESP, bus0.HRDATA); end
    checks++; if (st0 !== 4'b0 || irq0 !== 1'b0 || pa0 !== 128'h0 || sd0 !== 256'h0) begin errors++;
      $display("FAIL reset_outputs got start=%b irq=%b pa=%h", st0, irq0, pa0); end
  endtask

  task automatic test_rw_basic();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    t_sel = 1'b0;
    bus_xfer(1'b1, 32'h44, 32'h1000_0000, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b00 || w !== 0 || e1 !== 1'b0) begin errors++;
      $display("FAIL paddr2_write_resp got resp=%b waits=%0d exp 00/0", rs, w); end
    checks++; if (pa0[95:64] !== 32'h1000_0000) begin errors++;
      $display("FAIL paddr2_port got %h exp 10000000", pa0[95:64]); end
    bus_xfer(1'b0, 32'h44, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h1000_0000 || rs !== 2'b00 || w !== 0) begin errors++;
      $display("FAIL paddr2_read got %h/%b/%0d exp 10000000/00/0", rd, rs, w); end
  endtask

  task automatic test_start_busy();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    t_sel = 1'b0;
    bus_xfer(1'b1, 32'h20, 32'h3, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (st0 !== 4'b0010) begin errors++;
      $display("FAIL start_pulse got %b exp 0010", st0); end
    @(posedge clk); #1;
    checks++; if (st0 !== 4'b0000) begin errors++;
      $display("FAIL start_one_cycle got %b exp 0000", st0); end
    bus_xfer(1'b0, 32'h38, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h1) begin errors++;
      $display("FAIL status_busy got %h exp 1", rd); end
    bus_xfer(1'b0, 32'h20, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h2) begin errors++;
      $display("FAIL ctrl_ie_read got %h exp 2", rd); end
    bus_xfer(1'b1, 32'h24, 32'hDEAD_BEEF, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01 || e1 !== 1'b1) begin errors++;
      $display("FAIL paddr_busy_err got resp=%b err1=%b exp 01/1", rs, e1); end
    checks++; if (pa0[63:32] !== 32'h0) begin errors++;
      $display("FAIL paddr_busy_nochange got %h exp 0", pa0[63:32]); end
    bus_xfer(1'b1, 32'h20, 32'h1, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01 || st0 !== 4'b0000) begin errors++;
      $display("FAIL start_busy_err got resp=%b start=%b exp 01/0000", rs, st0); end
  endtask

  task automatic test_done_irq();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    t_sel = 1'b0;
    @(negedge clk); c_done = 4'b0010;
    @(negedge clk); c_done = 4'b0000;
    checks++; if (irq0 !== 1'b0) begin errors++;
      $display("FAIL irq_early got %b exp 0", irq0); end
    @(posedge clk); #1;
    checks++; if (irq0 !== 1'b1) begin errors++;
      $display("FAIL irq_set got %b exp 1", irq0); end
    bus_xfer(1'b0, 32'h38, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h2) begin errors++;
      $display("FAIL status_done got %h exp 2", rd); end
    bus_xfer(1'b1, 32'h20, 32'h3, HSIZE_WORD, rd, rs, w, e1);
    bus_xfer(1'b0, 32'h38, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h3) begin errors++;
      $display("FAIL status_done_busy got %h exp 3", rd); end
    // W1C of DONE in the same cycle as the completion pulse
    @(negedge clk);
    t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_hwrite = 1'b1; t_haddr = 32'h38; t_hsize = HSIZE_WORD;
    @(posedge clk); #1;
    t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = 32'h2; c_done = 4'b0010;
    @(negedge clk);
    checks++; if (m_rdy !== 1'b1 || m_resp !== 2'b00) begin errors++;
      $display("FAIL w1c_coincident_resp got %b/%b exp 1/00", m_rdy, m_resp); end
    @(posedge clk); #1; c_done = 4'b0000;
    bus_xfer(1'b0, 32'h38, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h2) begin errors++;
      $display("FAIL set_wins got %h exp 2", rd); end
    bus_xfer(1'b1, 32'h38, 32'h2, HSIZE_WORD, rd, rs, w, e1);
    @(posedge clk); #1;
    checks++; if (irq0 !== 1'b0) begin errors++;
      $display("FAIL irq_clear got %b exp 0", irq0); end
    @(negedge clk); c_done = 4'b0010;
    @(negedge clk); c_done = 4'b0000;
    bus_xfer(1'b0, 32'h38, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h0) begin errors++;
      $display("FAIL done_idle_ignored got %h exp 0", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    t_sel = 1'b0;
    bus_xfer(1'b1, 32'h04, 32'h1234, HSIZE_HALF, rd, rs, w, e1);
    checks++; if (rs !== 2'b01 || e1 !== 1'b1) begin errors++;
      $display("FAIL half_err got %b/%b exp 01/1", rs, e1); end
    bus_xfer(1'b0, 32'h04, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h0 || rs !== 2'b00) begin errors++;
      $display("FAIL half_nochange got %h/%b exp 0/00", rd, rs); end
    bus_xfer(1'b1, 32'h1C, 32'hFFFF_FFFF, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01 || e1 !== 1'b1) begin errors++;
      $display("FAIL rsvd_err got %b/%b exp 01/1", rs, e1); end
    bus_xfer(1'b0, 32'h80, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'hC0DE_0401 || rs !== 2'b00) begin errors++;
      $display("FAIL id_read got %h/%b exp c0de0401/00", rd, rs); end
    bus_xfer(1'b1, 32'h80, 32'h5, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01) begin errors++;
      $display("FAIL id_write_err got %b exp 01", rs); end
    bus_xfer(1'b0, 32'hA0, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01 || rd !== 32'h0) begin errors++;
      $display("FAIL unmapped_err got %b/%h exp 01/0", rs, rd); end
    bus_xfer(1'b0, 32'h46, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rs !== 2'b01) begin errors++;
      $display("FAIL misalign_err got %b exp 01", rs); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    bit got;
    t_sel = 1'b1;
    bus_xfer(1'b1, 32'h10, 32'hA5A5_1234, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (w !== 3 || rs !== 2'b00 || sd3[31:0] !== 32'hA5A5_1234) begin errors++;
      $display("FAIL ws_write got waits=%0d resp=%b seed=%h exp 3/00/a5a51234", w, rs, sd3[31:0]); end
    bus_xfer(1'b0, 32'h10, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (w !== 3 || rd !== 32'hA5A5_1234) begin errors++;
      $display("FAIL ws_read got waits=%0d data=%h exp 3/a5a51234", w, rd); end
    bus_xfer(1'b1, 32'h14, 32'h0, HSIZE_BYTE, rd, rs, w, e1);
    checks++; if (w !== 3 || e1 !== 1'b1 || rs !== 2'b01) begin errors++;
      $display("FAIL ws_err got waits=%0d err1=%b resp=%b exp 3/1/01", w, e1, rs); end
    // Pipelined write then read of the same register
    @(negedge clk);
    t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_hwrite = 1'b1; t_haddr = 32'h10; t_hsize = HSIZE_WORD;
    @(posedge clk); #1;
    t_hwdata = 32'h5A5A_0001; t_hwrite = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); got = m_rdy;
      @(posedge clk); #1;
    end
    t_hsel = 1'b0; t_htrans = HTRANS_IDLE;
    checks++; if (!got) begin errors++; $display("FAIL b2b_write_timeout got 0 exp 1"); end
    got = 1'b0; rd = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m_rdy) begin got = 1'b1; rd = m_rdata; end
    end
    @(posedge clk); #1;
    checks++; if (!got || rd !== 32'h5A5A_0001) begin errors++;
      $display("FAIL b2b_read got %h exp 5a5a0001", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; int w; logic e1;
    t_sel = 1'b1;
    @(negedge clk);
    t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_hwrite = 1'b1; t_haddr = 32'h6C; t_hsize = HSIZE_WORD;
    @(posedge clk); #1;
    t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = 32'hCAFE_F00D;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (m_rdy !== 1'b1 || m_resp !== 2'b00) begin errors++;
      $display("FAIL mid_reset_ready got %b/%b exp 1/00", m_rdy, m_resp); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ca3[127:96] !== 32'h0) begin errors++;
      $display("FAIL mid_reset_port got %h exp 0", ca3[127:96]); end
    bus_xfer(1'b0, 32'h6C, 32'h0, HSIZE_WORD, rd, rs, w, e1);
    checks++; if (rd !== 32'h0 || rs !== 2'b00) begin errors++;
      $display("FAIL mid_reset_read got %h/%b exp 0/00", rd, rs); end
  endtask

  initial begin
    test_reset();
    test_rw_basic();
    test_start_busy();
    test_done_irq();
    test_errors();
    test_wait_states();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
